formula_sweep_ctrl: RTL
=======================

Name: formula_sweep_ctrl

Overview:
Sequencer that exhaustively drives a combinational Boolean formula block (NIN inputs, 1 output) through all 2^NIN input assignments, one per clock.
Accumulates the satisfying-assignment count, the first satisfying assignment, and all-true/none-true flags.
Sits between the bench/host and any generated formula netlist, giving the netlists a uniform start/done evaluation wrapper.
Supports a formula path registered LAT cycles deep.

Parameters:
NIN, 7, number of formula inputs; sweep length 2^NIN
LAT, 0, pipeline latency of formula path in cycles (0 = purely combinational)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin sweep; sampled only in IDLE
abort  input  1  terminate sweep; sampled in RUN/DRAIN
vec_o  output  NIN  assignment driven to formula inputs (bit i -> formula input i)
f_i  input  1  formula output for vec_o presented LAT cycles earlier
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse on normal completion
aborted  output  1  set on abort, cleared on next accepted start
sat_count  output  NIN+1  number of assignments with f_i=1
first_valid  output  1  at least one satisfying assignment seen
first_sat  output  NIN  lowest-index satisfying assignment (valid when first_valid)
all_sat  output  1  sat_count == 2^NIN, valid with done
none_sat  output  1  sat_count == 0, valid with done

Behaviour:
- Async reset (rst_n=0): FSM=IDLE. Outputs vec_o=0, busy=0, done=0, aborted=0, sat_count=0, first_valid=0, first_sat=0, all_sat=0, none_sat=0. Pipeline valid bits cleared.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 at edge T0 -> RUN.
  - Same edge: clear sat_count, first_valid, first_sat, aborted, all_sat, none_sat.
  - vec_o=0.
- RUN:
  - vec_o = k during cycle T0+k, for k = 0 .. 2^NIN-1. Counter wraps to 0 after the last issue.
  - After issuing 2^NIN-1 -> DRAIN, or directly to completion if LAT=0.
- DRAIN:
  - Waits for the remaining LAT responses.
  - vec_o holds 0.
- Response tracking:
  - A LAT-deep shift register carries {valid, index} alongside the formula pipeline.
  - f_i for index k is sampled at edge T0+k+LAT+1.
  - On a valid sample with f_i=1: sat_count += 1. If first_valid=0, first_sat <= k and first_valid <= 1.
  - sat_count is NIN+1 bits wide and never saturates or wraps; its maximum is 2^NIN.
- Completion:
  - At edge T0+2^NIN+LAT: busy falls, done=1 for exactly one cycle, all_sat and none_sat update, FSM=IDLE.
  - Results hold until the next accepted start.
  - A start during the done cycle is accepted.
- Abort in RUN or DRAIN:
  - Next edge: FSM=IDLE, busy=0, aborted=1, done stays 0, pipeline valids flushed.
  - Partial sat_count and first_sat are retained; all_sat and none_sat stay 0.
- start and abort together in IDLE: abort is ignored, start is accepted.
- start while busy is ignored.
- f_i is ignored whenever no valid entry is at the pipeline head.
- Reset mid-sweep: immediate return to reset values; no done pulse.

Optional Feature:
FSWEEP_TRUTH_TABLE_EN
- Defined:
  - Adds output tt_o, width 2^NIN.
  - Bit k <= f_i when response k is sampled.
  - Whole register cleared on accepted start and on reset; holds after done.
  - Bits not yet sampled before an abort remain 0.
- Undefined: no tt_o port and no storage; all other behaviour is identical.

Test Plan:
- NIN=7, LAT=0, f = AND of all inputs; pulse start -> done 128 cycles after the start edge; sat_count=1, first_sat=7'h7F, first_valid=1, all_sat=0, none_sat=0.
- NIN=7, LAT=0, f tied 0 -> sat_count=0, first_valid=0, none_sat=1; vec_o sequence 0..127 observed in consecutive cycles.
- NIN=7, LAT=2, f = registered input bit 0 -> done at start edge+130; sat_count=64, first_sat=1; f tied 1 variant -> sat_count=128 (8'h80), all_sat=1, first_sat=0.
- Abort asserted in cycle T0+10 with f tied 1, LAT=0 -> aborted=1, done never pulses, busy falls the next edge, sat_count=10 or 11 per sampled edges (expect 11 if abort is seen at edge T0+11), all_sat=0.
- start held high through the whole sweep and the done cycle -> exactly one sweep runs while busy; the second sweep starts on the done cycle; aborted cleared.
- rst_n pulsed low mid-RUN -> all outputs return to 0 asynchronously without waiting for a clock; a subsequent start gives a correct full sweep. With FSWEEP_TRUTH_TABLE_EN and f = input bit 0 XOR input bit 1 -> tt_o = repeating 4'b0110 pattern.

Source files
------------

// File: rtl/formula_sweep_ctrl.sv
// Purpose : sweeps a 1-output Boolean formula through all 2^NIN input assignments and
//           accumulates satisfying count, first satisfying assignment and all/none flags.
// Latency : one assignment per clock; done pulses 2^NIN+LAT edges after the start edge.
// Backpressure: none; start is ignored while busy, abort ends a sweep on the next edge.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   start, abort          begin a sweep (IDLE only) / terminate a sweep (RUN/DRAIN only)
//   vec_o                 assignment presented to the formula (bit i -> formula input i)
//   f_i                   formula result for the vec_o issued LAT cycles earlier
//   busy, done, aborted   sweep status
//   sat_count, first_valid, first_sat, all_sat, none_sat   sweep results
//   tt_o                  full truth table (only when FSWEEP_TRUTH_TABLE_EN is defined)
module formula_sweep_ctrl #(
  parameter int NIN = 7,
  parameter int LAT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  output logic [NIN-1:0] vec_o,
  input  logic           f_i,
  output logic           busy,
  output logic           done,
  output logic           aborted,
  output logic [NIN:0]   sat_count,
  output logic           first_valid,
  output logic [NIN-1:0] first_sat,
  output logic           all_sat,
  output logic           none_sat
`ifdef FSWEEP_TRUTH_TABLE_EN
  ,
  output logic [(1<<NIN)-1:0] tt_o
`endif
);

  localparam logic [NIN-1:0] LAST = {NIN{1'b1}};
  localparam logic [NIN:0]   FULL = {1'b1, {NIN{1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t         state, state_nxt;
  logic [NIN-1:0] cnt;
  logic           issue_vld;
  logic [NIN-1:0] issue_idx;
  logic           head_vld;
  logic [NIN-1:0] head_idx;
  logic           hit;
  logic           finish;
  logic           kill;
  logic [NIN:0]   sat_nxt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state. The sweep finishes on the edge that samples the last index,
  // which for LAT=0 is the same edge that retires the last issue.
  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        if (abort) state_nxt = IDLE;
        else if (cnt == LAST) state_nxt = (LAT == 0) ? IDLE : DRAIN;
        finish = !abort && head_vld && (head_idx == LAST);
      end
      DRAIN: begin
        finish = !abort && head_vld && (head_idx == LAST);
        if (abort || finish) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy      = (state != IDLE);
    issue_vld = (state == RUN);
    issue_idx = cnt;
    vec_o     = issue_vld ? cnt : '0;
  end

  assign kill = busy && abort;

  // Assignment counter: wraps to 0 after the last issue, held at 0 otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt <= '0;
    else if (issue_vld && !abort)   cnt <= cnt + 1'b1;
    else                            cnt <= '0;
  end

  // {valid, index} tracker running alongside the formula's own pipeline
  generate
    if (LAT == 0) begin : g_comb
      assign head_vld = issue_vld;
      assign head_idx = issue_idx;
    end else begin : g_pipe
      logic [LAT-1:0]          pv;
      logic [LAT-1:0][NIN-1:0] pidx;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pv   <= '0;
          pidx <= '0;
        end else begin
          pv[0]   <= issue_vld && !kill;
          pidx[0] <= issue_idx;
          for (int i = 1; i < LAT; i++) begin
            pv[i]   <= pv[i-1] && !kill;
            pidx[i] <= pidx[i-1];
          end
        end
      end
      assign head_vld = pv[LAT-1];
      assign head_idx = pidx[LAT-1];
    end
  endgenerate

  // The response sampled on an abort edge still counts; only later ones are dropped
  assign hit     = head_vld && f_i;
  assign sat_nxt = sat_count + {{NIN{1'b0}}, hit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done        <= 1'b0;
      aborted     <= 1'b0;
      sat_count   <= '0;
      first_valid <= 1'b0;
      first_sat   <= '0;
      all_sat     <= 1'b0;
      none_sat    <= 1'b0;
`ifdef FSWEEP_TRUTH_TABLE_EN
      tt_o        <= '0;
`endif
    end else begin
      done <= finish;
      if (state == IDLE && start) begin
        aborted     <= 1'b0;
        sat_count   <= '0;
        first_valid <= 1'b0;
        first_sat   <= '0;
        all_sat     <= 1'b0;
        none_sat    <= 1'b0;
`ifdef FSWEEP_TRUTH_TABLE_EN
        tt_o        <= '0;
`endif
      end else begin
        sat_count <= sat_nxt;
        if (hit && !first_valid) begin
          first_valid <= 1'b1;
          first_sat   <= head_idx;
        end
`ifdef FSWEEP_TRUTH_TABLE_EN
        if (head_vld) tt_o[head_idx] <= f_i;
`endif
        if (kill) aborted <= 1'b1;
        if (finish) begin
          all_sat  <= (sat_nxt == FULL);
          none_sat <= (sat_nxt == '0);
        end
      end
    end
  end

endmodule
